hsv_enhance_ctrl: RTL and testbench
===================================

// Module: hsv_enhance_ctrl
// PURPOSE
//  Frame-synchronous HSV adjuster: per-channel signed offsets for hue, saturation and brightness.
//  Offsets are driven by inc/dec buttons sampled on vsync falling edge, with hold-to-accelerate.
//  Applied to a valid-qualified pixel stream in a 2-stage pipeline: hue wraps, S/V saturate.
//  Sits between the RGB->HSV converter and the HSV->RGB converter in the passport video path.
// PARAMETERS
//  DW          8    bits per HSV channel
//  H_MAX       255  largest legal hue code (e.g. 179 for 180-step hue); hue arithmetic is mod H_MAX+1
//  H_STEP      1    hue offset step per frame
//  S_STEP      1    saturation offset step per frame
//  V_STEP      1    brightness offset step per frame
//  MAX_OFS     255  S/V offset magnitude limit, <= 2^DW-1
//  ACCEL_FRAMES 4   consecutive same-direction frames before the step is multiplied
//  ACCEL_MULT  4    step multiplier once accelerated
// PORTS
//  clk            in   1      pixel clock
//  rst            in   1      asynchronous, active-high reset
//  vsync          in   1      frame sync; falling edge is the offset update point
//  enhance_en     in   1      1 = apply offsets; 0 = bypass, same latency
//  inc_hue/dec_hue, inc_saturation/dec_saturation, inc_brightness/dec_brightness  in 1 each: level buttons
//  reset_enhance  in   1      request to clear all offsets and hold counters
//  pix_valid_in   in   1      hsv_in qualifier
//  hsv_in         in   3*DW   {H,S,V}
//  pix_valid_out  out  1      hsv_out qualifier
//  hsv_out        out  3*DW   adjusted {H,S,V}
//  h_offset       out  DW     current hue offset, 0..H_MAX (rotation)
//  s_offset, v_offset  out  DW+1  current signed offsets, two's complement, -MAX_OFS..+MAX_OFS
// BEHAVIOUR
//  - rst: hsv_out=0, pix_valid_out=0, all offsets=0, hold counters=0, pending clear=0, vsync_q=0.
//  - vsync_fall = vsync_q & ~vsync (registered vsync_q). Offsets change only on a vsync_fall cycle,
//    so every pixel of a frame sees the same offsets.
//  - reset_enhance: set a sticky pending-clear flag. On the next vsync_fall, zero all offsets and hold
//    counters and drop the flag. Button inputs on that edge are ignored.
//  - Per channel on vsync_fall: exactly one of inc/dec asserted -> step in that direction.
//    Neither or both asserted -> offset holds and hold_cnt clears.
//  - Step = STEP if hold_cnt < ACCEL_FRAMES, else STEP*ACCEL_MULT. hold_cnt is the count before the edge.
//    Same direction as the previous edge -> hold_cnt increments, saturating at ACCEL_FRAMES.
//    New direction -> hold_cnt=1.
//  - S/V offset: signed add, clamped to +/-MAX_OFS. Sign crossing through 0 is seamless (-1 +1 = 0).
//  - Hue offset: (h_offset +/- step) mod (H_MAX+1); never out of range.
//  - Pipeline, 2 cycles in enhance and bypass modes: pix_valid_out = pix_valid_in delayed 2 cycles.
//    Data regs load only when their stage's valid is set, otherwise they hold.
//    S1: register inputs; compute sums at DW+2 bits signed; clamp H input > H_MAX to H_MAX.
//    S2: S/V result clamped to [0, 2^DW-1]. H result = sum - (H_MAX+1) if sum > H_MAX.
//  - enhance_en is sampled in S1 and travels with the pixel. Toggling it mid-frame affects only later pixels.
//  - Async rst mid-stream: valid pipe and offsets clear immediately. In-flight pixels are dropped.
// STRUCTURE
//  - enhance_defs.vh: DW default, HSV field slice localparams (H_MSB..V_LSB), OFS_W=DW+1.
//  - Sub-module enh_offset_acc (one per channel; param STEP, LIMIT, WRAP mode, ACCEL_*).
//    Holds offset reg, hold_cnt, last-direction; inputs vsync_fall, inc, dec, clear.
//  - Top: vsync edge detect, pending-clear flag, 3x enh_offset_acc, 2-stage pixel pipe.
// TESTING
//  1 rst, enhance_en=1, no buttons, valid pixel 0x40_80_C0 -> hsv_out=0x40_80_C0, pix_valid_out 2 clk later.
//  2 inc_brightness held 3 vsync falls -> v_offset=+3; V=0x10 -> 0x13; V=0xFE -> 0xFF (saturate).
//  3 dec_saturation held 5 falls -> s_offset=-5 (0x1FB); S=0x03 -> 0x00; then inc+dec together -> stays -5.
//  4 H_MAX=179, inc_hue to h_offset=10; H=175 -> 5; dec_hue 11 frames from 0 -> h_offset=169.
//  5 ACCEL_FRAMES=4, ACCEL_MULT=4, inc_saturation held 6 falls -> s_offset sequence 1,2,3,4,8,12.
//  6 reset_enhance pulse mid-frame -> offsets unchanged until next vsync_fall, then 0.
//    rst mid-stream -> pix_valid_out=0 same cycle.
//    enhance_en=0 with offsets nonzero -> pixels pass unchanged at 2-clk latency.

Source files
------------

// File: rtl/hsv_enhance_ctrl_pkg.sv
// Shared types and defaults for the HSV enhancement block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hsv_enhance_ctrl_pkg;

    // Default bits per HSV channel.
    localparam int DEF_DW = 8;

    // Direction of the button that was acted on at the last vsync falling edge.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_INC  = 2'd1,
        DIR_DEC  = 2'd2
    } dir_t;

    // Offset accumulator arithmetic: signed clamp (S/V) or modular rotation (H).
    typedef enum logic {
        ACC_SAT  = 1'b0,
        ACC_WRAP = 1'b1
    } acc_mode_t;

endpackage

// File: rtl/hsv_enhance_ctrl_offset_acc.sv
// Per-channel offset accumulator stepped by inc/dec buttons on vsync falling edges, with hold-to-accelerate.
// Latency: offset updates on the clock edge that ends a vsync_fall cycle.
// Backpressure: none; buttons are level inputs sampled only when vsync_fall is high.
// Ports: clk, rst (async, active-high); vsync_fall/inc/dec/clear strobes in; offset out
//        (unsigned 0..LIMIT in ACC_WRAP mode, two's complement -LIMIT..+LIMIT in ACC_SAT mode).
module enh_offset_acc
    import hsv_enhance_ctrl_pkg::*;
#(
    parameter int        W            = 9,
    parameter int        STEP         = 1,
    parameter int        LIMIT        = 255,
    parameter acc_mode_t MODE         = ACC_SAT,
    parameter int        ACCEL_FRAMES = 4,
    parameter int        ACCEL_MULT   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vsync_fall,
    input  logic         inc,
    input  logic         dec,
    input  logic         clear,
    output logic [W-1:0] offset
);

    // Extra headroom so the counter can hold ACCEL_FRAMES even when it is 0.
    localparam int CW  = $clog2(ACCEL_FRAMES + 2);
    localparam int MOD = LIMIT + 1;
    // In wrap mode the step is pre-reduced so a single conditional correction suffices.
    localparam int STEP_LO = (MODE == ACC_WRAP) ? (STEP % MOD) : STEP;
    localparam int STEP_HI = (MODE == ACC_WRAP) ? ((STEP * ACCEL_MULT) % MOD) : (STEP * ACCEL_MULT);

    logic [W-1:0]  offset_nxt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_nxt;
    dir_t          last_dir;
    dir_t          dir_nxt;
    dir_t          req;
    int            cur;
    int            stp;
    int            sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset   <= '0;
            hold_cnt <= '0;
            last_dir <= DIR_NONE;
        end else begin
            offset   <= offset_nxt;
            hold_cnt <= hold_nxt;
            last_dir <= dir_nxt;
        end
    end

    always_comb begin
        offset_nxt = offset;
        hold_nxt   = hold_cnt;
        dir_nxt    = last_dir;
        req        = DIR_NONE;
        cur        = 0;
        stp        = 0;
        sum        = 0;

        if (inc && !dec) begin
            req = DIR_INC;
        end else if (dec && !inc) begin
            req = DIR_DEC;
        end

        if (MODE == ACC_WRAP) begin
            cur = int'(offset);
        end else begin
            cur = int'($signed(offset));
        end

        // Step size depends on the hold count as it stood before this edge.
        stp = (int'(hold_cnt) < ACCEL_FRAMES) ? STEP_LO : STEP_HI;
        sum = (req == DIR_DEC) ? (cur - stp) : (cur + stp);

        if (MODE == ACC_WRAP) begin
            if (sum > LIMIT) begin
                sum = sum - MOD;
            end else if (sum < 0) begin
                sum = sum + MOD;
            end
        end else begin
            if (sum > LIMIT) begin
                sum = LIMIT;
            end else if (sum < -LIMIT) begin
                sum = -LIMIT;
            end
        end

        if (vsync_fall) begin
            if (clear) begin
                offset_nxt = '0;
                hold_nxt   = '0;
                dir_nxt    = DIR_NONE;
            end else if (req != DIR_NONE) begin
                offset_nxt = W'(sum);
                dir_nxt    = req;
                if (req == last_dir) begin
                    hold_nxt = (int'(hold_cnt) >= ACCEL_FRAMES) ? hold_cnt : (hold_cnt + CW'(1));
                end else begin
                    hold_nxt = CW'(1);
                end
            end else begin
                hold_nxt = '0;
                dir_nxt  = DIR_NONE;
            end
        end
    end

endmodule

// File: rtl/hsv_enhance_ctrl.sv
// Frame-synchronous HSV adjuster: button-driven per-channel offsets, hue rotates, S/V saturate.
// Latency: 2 clk from pix_valid_in to pix_valid_out in both enhance and bypass modes.
// Backpressure: none; every valid input pixel appears at the output two cycles later.
// Ports: clk, rst (async, active-high); vsync, enhance_en, six level buttons, reset_enhance;
//        pix_valid_in/hsv_in {H,S,V} in; pix_valid_out/hsv_out out; h_offset, s_offset, v_offset out.
module hsv_enhance_ctrl
    import hsv_enhance_ctrl_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int H_MAX        = 255,
    parameter int H_STEP       = 1,
    parameter int S_STEP       = 1,
    parameter int V_STEP       = 1,
    parameter int MAX_OFS      = 255,
    parameter int ACCEL_FRAMES = 4,
    parameter int ACCEL_MULT   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vsync,
    input  logic            enhance_en,
    input  logic            inc_hue,
    input  logic            dec_hue,
    input  logic            inc_saturation,
    input  logic            dec_saturation,
    input  logic            inc_brightness,
    input  logic            dec_brightness,
    input  logic            reset_enhance,
    input  logic            pix_valid_in,
    input  logic [3*DW-1:0] hsv_in,
    output logic            pix_valid_out,
    output logic [3*DW-1:0] hsv_out,
    output logic [DW-1:0]   h_offset,
    output logic [DW:0]     s_offset,
    output logic [DW:0]     v_offset
);

    localparam int OFS_W = DW + 1;
    localparam int SW    = DW + 2;
    localparam int H_MSB = 3*DW - 1;
    localparam int H_LSB = 2*DW;
    localparam int S_MSB = 2*DW - 1;
    localparam int S_LSB = DW;
    localparam int V_MSB = DW - 1;
    localparam int V_LSB = 0;

    localparam logic [DW-1:0]        H_MAX_C  = DW'(H_MAX);
    localparam logic signed [SW-1:0] H_MOD_C  = SW'(H_MAX + 1);
    localparam logic signed [SW-1:0] PIX_MAX  = SW'((1 << DW) - 1);

    // ---------------- frame sync and offset control ----------------
    logic vsync_q;
    logic vsync_fall;
    logic clr_pend;

    assign vsync_fall = vsync_q & ~vsync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            // A request landing on the edge cycle itself is kept for the following frame.
            clr_pend <= (clr_pend & ~vsync_fall) | reset_enhance;
        end
    end

    enh_offset_acc #(
        .W(DW), .STEP(H_STEP), .LIMIT(H_MAX), .MODE(ACC_WRAP),
        .ACCEL_FRAMES(ACCEL_FRAMES), .ACCEL_MULT(ACCEL_MULT)
    ) u_hue_acc (
        .clk(clk), .rst(rst), .vsync_fall(vsync_fall),
        .inc(inc_hue), .dec(dec_hue), .clear(clr_pend), .offset(h_offset)
    );

    enh_offset_acc #(
        .W(OFS_W), .STEP(S_STEP), .LIMIT(MAX_OFS), .MODE(ACC_SAT),
        .ACCEL_FRAMES(ACCEL_FRAMES), .ACCEL_MULT(ACCEL_MULT)
    ) u_sat_acc (
        .clk(clk), .rst(rst), .vsync_fall(vsync_fall),
        .inc(inc_saturation), .dec(dec_saturation), .clear(clr_pend), .offset(s_offset)
    );

    enh_offset_acc #(
        .W(OFS_W), .STEP(V_STEP), .LIMIT(MAX_OFS), .MODE(ACC_SAT),
        .ACCEL_FRAMES(ACCEL_FRAMES), .ACCEL_MULT(ACCEL_MULT)
    ) u_val_acc (
        .clk(clk), .rst(rst), .vsync_fall(vsync_fall),
        .inc(inc_brightness), .dec(dec_brightness), .clear(clr_pend), .offset(v_offset)
    );

    // ---------------- stage 1: clamp hue, form wide sums ----------------
    logic [DW-1:0]        h_in;
    logic [DW-1:0]        h_clamp;
    logic signed [SW-1:0] h_sum_c;
    logic signed [SW-1:0] s_sum_c;
    logic signed [SW-1:0] v_sum_c;

    assign h_in    = hsv_in[H_MSB:H_LSB];
    assign h_clamp = (h_in > H_MAX_C) ? H_MAX_C : h_in;
    assign h_sum_c = $signed({2'b00, h_clamp}) + $signed({2'b00, h_offset});
    assign s_sum_c = $signed({2'b00, hsv_in[S_MSB:S_LSB]}) + $signed({s_offset[OFS_W-1], s_offset});
    assign v_sum_c = $signed({2'b00, hsv_in[V_MSB:V_LSB]}) + $signed({v_offset[OFS_W-1], v_offset});

    logic                 vld1;
    logic                 en1;
    logic signed [SW-1:0] h_sum1;
    logic signed [SW-1:0] s_sum1;
    logic signed [SW-1:0] v_sum1;
    logic [3*DW-1:0]      raw1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1   <= 1'b0;
            en1    <= 1'b0;
            h_sum1 <= '0;
            s_sum1 <= '0;
            v_sum1 <= '0;
            raw1   <= '0;
        end else begin
            vld1 <= pix_valid_in;
            // The enable travels with the pixel so a mid-frame toggle only affects later pixels.
            if (pix_valid_in) begin
                en1    <= enhance_en;
                h_sum1 <= h_sum_c;
                s_sum1 <= s_sum_c;
                v_sum1 <= v_sum_c;
                raw1   <= hsv_in;
            end
        end
    end

    // ---------------- stage 2: wrap hue, saturate S/V ----------------
    function automatic logic [DW-1:0] clamp_pix(input logic signed [SW-1:0] x);
        logic [DW-1:0] r;
        if (x < 0) begin
            r = '0;
        end else if (x > PIX_MAX) begin
            r = '1;
        end else begin
            r = DW'(x);
        end
        return r;
    endfunction

    logic [DW-1:0] h_wrap;
    logic [DW-1:0] h_res;

    // Both operands are <= H_MAX, so one subtraction brings the sum back into range.
    assign h_wrap = DW'(h_sum1 - H_MOD_C);
    assign h_res  = (h_sum1 >= H_MOD_C) ? h_wrap : DW'(h_sum1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_out <= 1'b0;
            hsv_out       <= '0;
        end else begin
            pix_valid_out <= vld1;
            if (vld1) begin
                hsv_out <= en1 ? {h_res, clamp_pix(s_sum1), clamp_pix(v_sum1)} : raw1;
            end
        end
    end

endmodule

// File: tb/tb_hsv_enhance_ctrl.sv
module tb_hsv_enhance_ctrl;

    localparam int HM   = 179;
    localparam int MAXO = 255;
    localparam int AF   = 4;
    localparam int AM   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        enhance_en;
    logic        inc_hue, dec_hue, inc_saturation, dec_saturation, inc_brightness, dec_brightness;
    logic        reset_enhance;
    logic        pix_valid_in;
    logic [23:0] hsv_in;
    logic        pix_valid_out;
    logic [23:0] hsv_out;
    logic [7:0]  h_offset;
    logic [8:0]  s_offset;
    logic [8:0]  v_offset;

    hsv_enhance_ctrl #(
        .DW(8), .H_MAX(HM), .H_STEP(1), .S_STEP(1), .V_STEP(1),
        .MAX_OFS(MAXO), .ACCEL_FRAMES(AF), .ACCEL_MULT(AM)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .enhance_en(enhance_en),
        .inc_hue(inc_hue), .dec_hue(dec_hue),
        .inc_saturation(inc_saturation), .dec_saturation(dec_saturation),
        .inc_brightness(inc_brightness), .dec_brightness(dec_brightness),
        .reset_enhance(reset_enhance), .pix_valid_in(pix_valid_in), .hsv_in(hsv_in),
        .pix_valid_out(pix_valid_out), .hsv_out(hsv_out),
        .h_offset(h_offset), .s_offset(s_offset), .v_offset(v_offset)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] d;
        int          ts;
    } exp_t;
    exp_t sb[$];

    // Reference offsets: index 0=H, 1=S, 2=V.
    int m_ofs[3];
    int m_hold[3];
    int m_dir[3];
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_ofs[c]  = 0;
            m_hold[c] = 0;
            m_dir[c]  = 0;
        end
        m_pend = 0;
    endtask

    task automatic model_fall(input bit [2:0] inc, input bit [2:0] dec);
        int d, st, v;
        if (m_pend) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            d = (inc[c] && !dec[c]) ? 1 : ((dec[c] && !inc[c]) ? -1 : 0);
            if (d == 0) begin
                m_hold[c] = 0;
                m_dir[c]  = 0;
            end else begin
                st = (m_hold[c] < AF) ? 1 : AM;
                v  = m_ofs[c] + d * st;
                if (c == 0) begin
                    v = ((v % (HM + 1)) + (HM + 1)) % (HM + 1);
                end else begin
                    if (v > MAXO)  v = MAXO;
                    if (v < -MAXO) v = -MAXO;
                end
                m_ofs[c] = v;
                if (d == m_dir[c]) m_hold[c] = (m_hold[c] < AF) ? m_hold[c] + 1 : AF;
                else               m_hold[c] = 1;
                m_dir[c] = d;
            end
        end
    endtask

    task automatic chk_ofs(input string tag);
        int          ih, is, iv;
        logic [7:0]  eh;
        logic [8:0]  es, ev;
        ih = m_ofs[0]; is = m_ofs[1]; iv = m_ofs[2];
        eh = ih[7:0];
        es = is[8:0];
        ev = iv[8:0];
        chk({tag, "_h"}, 32'(h_offset), 32'(eh));
        chk({tag, "_s"}, 32'(s_offset), 32'(es));
        chk({tag, "_v"}, 32'(v_offset), 32'(ev));
    endtask

    // One frame boundary: vsync high for two clocks, then low with the buttons held across the edge.
    task automatic frame(input bit [2:0] inc, input bit [2:0] dec);
        vsync = 1'b1;
        tick(2);
        inc_hue = inc[0]; inc_saturation = inc[1]; inc_brightness = inc[2];
        dec_hue = dec[0]; dec_saturation = dec[1]; dec_brightness = dec[2];
        vsync = 1'b0;
        tick(2);
        inc_hue = 0; inc_saturation = 0; inc_brightness = 0;
        dec_hue = 0; dec_saturation = 0; dec_brightness = 0;
        model_fall(inc, dec);
    endtask

    task automatic pix(input logic [23:0] d, input bit en);
        int   h, s, v;
        exp_t e;
        h = int'(d[23:16]);
        s = int'(d[15:8]);
        v = int'(d[7:0]);
        if (h > HM) h = HM;
        h = h + m_ofs[0];
        if (h >= HM + 1) h = h - (HM + 1);
        s = s + m_ofs[1];
        v = v + m_ofs[2];
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        e.d  = en ? {8'(h), 8'(s), 8'(v)} : d;
        e.ts = cyc;
        sb.push_back(e);
        pix_valid_in = 1'b1;
        hsv_in       = d;
        enhance_en   = en;
        tick();
        pix_valid_in = 1'b0;
    endtask

    // Output side of the scoreboard.
    exp_t got_e;
    always @(negedge clk) begin
        if (!rst && pix_valid_out) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(pix_valid_out), 32'd0);
            end else begin
                got_e = sb.pop_front();
                chk("pix_data", 32'(hsv_out), 32'(got_e.d));
                chk("pix_lat", 32'(cyc - got_e.ts), 32'd2);
            end
        end
    end

    initial begin
        int seq[6];
        seq = '{1, 2, 3, 4, 8, 12};

        rst = 1'b1; vsync = 1'b0; enhance_en = 1'b1;
        inc_hue = 0; dec_hue = 0; inc_saturation = 0; dec_saturation = 0;
        inc_brightness = 0; dec_brightness = 0; reset_enhance = 0;
        pix_valid_in = 0; hsv_in = '0;
        model_reset();
        tick(3);
        chk("rst_hsv_out", 32'(hsv_out), 32'd0);
        chk("rst_valid", 32'(pix_valid_out), 32'd0);
        chk_ofs("rst_ofs");
        rst = 1'b0;
        tick(2);

        // Identity with zero offsets.
        pix(24'h4080C0, 1);
        tick(3);
        chk("t1_drain", 32'(sb.size()), 32'd0);

        // Brightness up three frames, including upper saturation of V.
        for (int i = 0; i < 3; i++) begin
            frame(3'b100, 3'b000);
            chk_ofs("t2_ofs");
        end
        chk("t2_v_ofs", 32'(v_offset), 32'h003);
        pix(24'h408010, 1);
        pix(24'h4080FE, 1);
        tick(3);

        // Clear request mid-frame holds until the next edge; buttons on that edge are ignored.
        reset_enhance = 1'b1;
        tick();
        reset_enhance = 1'b0;
        m_pend = 1;
        tick(3);
        chk("t6_hold_v", 32'(v_offset), 32'h003);
        frame(3'b001, 3'b000);
        chk_ofs("t6_clr");
        chk("t6_clr_v", 32'(v_offset), 32'h000);

        // Saturation down to -5, S saturates at 0, both buttons hold.
        for (int i = 0; i < 4; i++) frame(3'b000, 3'b010);
        frame(3'b000, 3'b000);
        frame(3'b000, 3'b010);
        chk("t3_s_m5", 32'(s_offset), 32'h1FB);
        chk_ofs("t3_ofs");
        pix(24'h200350, 1);
        frame(3'b010, 3'b010);
        chk("t3_both", 32'(s_offset), 32'h1FB);
        tick(3);

        // Acceleration sequence from zero.
        reset_enhance = 1'b1; tick(); reset_enhance = 1'b0; m_pend = 1;
        frame(3'b000, 3'b000);
        for (int i = 0; i < 6; i++) begin
            frame(3'b010, 3'b000);
            chk($sformatf("t5_acc%0d", i), 32'(s_offset), 32'(seq[i]));
        end
        chk_ofs("t5_ofs");

        // Hue rotation with H_MAX=179 using pulsed presses (no acceleration).
        reset_enhance = 1'b1; tick(); reset_enhance = 1'b0; m_pend = 1;
        frame(3'b000, 3'b000);
        for (int i = 0; i < 10; i++) begin
            frame(3'b001, 3'b000);
            frame(3'b000, 3'b000);
        end
        chk("t4_h10", 32'(h_offset), 32'd10);
        pix(24'hAF1020, 1);
        pix(24'hC81020, 1);
        tick(3);
        reset_enhance = 1'b1; tick(); reset_enhance = 1'b0; m_pend = 1;
        frame(3'b000, 3'b000);
        for (int i = 0; i < 11; i++) begin
            frame(3'b000, 3'b001);
            frame(3'b000, 3'b000);
        end
        chk("t4_h169", 32'(h_offset), 32'd169);
        chk_ofs("t4_ofs");

        // Offset limits for brightness.
        for (int i = 0; i < 70; i++) frame(3'b100, 3'b000);
        chk("lim_v_pos", 32'(v_offset), 32'h0FF);
        pix(24'h108080, 1);
        tick(3);
        for (int i = 0; i < 140; i++) frame(3'b000, 3'b100);
        chk("lim_v_neg", 32'(v_offset), 32'h101);
        chk_ofs("lim_ofs");
        pix(24'h1080FE, 1);
        tick(3);

        // Bypass with nonzero offsets, and enable toggling between adjacent pixels.
        pix(24'h123456, 0);
        pix(24'h22A0F0, 1);
        pix(24'h22A0F0, 0);
        pix(24'hB40505, 1);
        tick(3);
        chk("byp_drain", 32'(sb.size()), 32'd0);

        // Asynchronous reset with pixels in flight.
        pix(24'h010203, 1);
        pix(24'h040506, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(pix_valid_out), 32'd0);
        chk("arst_v_ofs", 32'(v_offset), 32'd0);
        sb.delete();
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("arst_after_valid", 32'(pix_valid_out), 32'd0);
        chk_ofs("arst_ofs");
        pix(24'h405060, 1);
        tick(4);
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
